// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: serial RX framing controller (start detect, mid-bit strobes, stop/parity check, byte buffer)
//
// Optional feature: define RX_PARITY_EN to expect one even-parity bit after the data bits.
// Ports:
//   clk            system clock, posedge
//   n_rst          asynchronous active-low reset
//   serial_in      synchronized serial line, idle high
//   sr_data        parallel word of the downstream shift register (stop bit in the MSB)
//   data_read      host pulse, current rx_data consumed
//   shift_strobe   one-cycle shift enable to the shift register
//   rx_data        last good received byte
//   data_ready     rx_data valid and unread
//   overrun_error  a byte was loaded while the previous one was unread
//   framing_error  last frame had a zero stop bit
//   parity_error   (RX_PARITY_EN only) last frame failed even parity
module rx_frame_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
`ifdef RX_PARITY_EN
    input  logic [DATA_BITS+1:0] sr_data,
`else
    input  logic [DATA_BITS:0]   sr_data,
`endif
    input  logic                 data_read,
    output logic                 shift_strobe,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
`ifdef RX_PARITY_EN
    output logic                 framing_error,
    output logic                 parity_error
`else
    output logic                 framing_error
`endif
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 2);
`ifdef RX_PARITY_EN
    localparam int NSTR = DATA_BITS + 2;
    localparam int STOP = DATA_BITS + 1;
`else
    localparam int NSTR = DATA_BITS + 1;
    localparam int STOP = DATA_BITS;
`endif
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST    = BW'(NSTR - 1);

    typedef enum logic [2:0] {IDLE, START_CHK, SAMPLE, CHECK, LOAD} state_t;

    state_t               state_q, state_d;
    logic                 line_q;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 ready_q, ready_d;
    logic                 ovr_q, ovr_d;
    logic                 fe_q, fe_d;
`ifdef RX_PARITY_EN
    logic                 pe_q, pe_d;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            line_q    <= 1'b1;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
`ifdef RX_PARITY_EN
            pe_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            line_q    <= serial_in;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
`ifdef RX_PARITY_EN
            pe_q      <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        ready_d      = ready_q;
        ovr_d        = ovr_q;
        fe_d         = fe_q;
`ifdef RX_PARITY_EN
        pe_d         = pe_q;
`endif
        shift_strobe = 1'b0;
        if (data_read && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
        case (state_q)
            IDLE: if (line_q && !serial_in) begin
                state_d = START_CHK;
                timer_d = HALF_M1;
                fe_d    = 1'b0;
`ifdef RX_PARITY_EN
                pe_d    = 1'b0;
`endif
            end
            // Mid-point of the start bit: a high line here was only a glitch
            START_CHK: if (timer_q != '0) timer_d = timer_q - 1'b1;
                else if (!serial_in) begin
                    state_d   = SAMPLE;
                    timer_d   = FULL_M1;
                    bit_cnt_d = '0;
                end else state_d = IDLE;
            SAMPLE: if (timer_q != '0) timer_d = timer_q - 1'b1;
                else begin
                    shift_strobe = 1'b1;
                    bit_cnt_d    = bit_cnt_q + 1'b1;
                    timer_d      = FULL_M1;
                    state_d      = (bit_cnt_q == LAST) ? CHECK : SAMPLE;
                end
            // Stop bit was shifted in on the last strobe edge and now sits in the MSB
            CHECK: begin
                state_d = sr_data[STOP] ? LOAD : IDLE;
                fe_d    = !sr_data[STOP];
`ifdef RX_PARITY_EN
                pe_d    = ^sr_data[DATA_BITS:0];
`endif
            end
            // A coincident data_read already cleared ready_d/ovr_d above, so load wins without overrun
            LOAD: begin
                rx_data_d = sr_data[DATA_BITS-1:0];
                ready_d   = 1'b1;
                ovr_d     = (ready_q && !data_read) ? 1'b1 : ovr_d;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = ovr_q;
    assign framing_error = fe_q;
`ifdef RX_PARITY_EN
    assign parity_error  = pe_q;
`endif
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed and randomized frames checked against a frame-level reference model
module tb_rx_frame_ctrl;
    logic       clk = 1'b0, n_rst = 1'b0, serial_in = 1'b1, data_read = 1'b0;
    logic [8:0] sr_data;
    logic       shift_strobe;
    logic [7:0] rx_data;
    logic       data_ready, overrun_error, framing_error;

    int   total = 0, bad = 0, cyc = 0, t0 = 0;
    int   stb_q[$];
    logic stb_n = 1'b0, sin_n = 1'b1;
    logic rdy96, rdy97;
    logic [7:0] rxd97;
    logic [7:0] e_data = 8'h00;
    logic e_rdy = 1'b0, e_ovr = 1'b0, e_fe = 1'b0;

    rx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(10)) dut (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .sr_data(sr_data),
        .data_read(data_read), .shift_strobe(shift_strobe), .rx_data(rx_data),
        .data_ready(data_ready), .overrun_error(overrun_error), .framing_error(framing_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe seen between edges lands on the next posedge (cyc+1)
    always @(negedge clk) begin
        stb_n = shift_strobe;
        sin_n = serial_in;
        if (shift_strobe) stb_q.push_back(cyc + 1);
    end

    // Downstream shift register: right shift, new bit enters the MSB
    always @(posedge clk or negedge n_rst)
        if (!n_rst) sr_data <= '1;
        else if (stb_n) sr_data <= {sin_n, sr_data[8:1]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'(e_data));
        chk({tag, "_ready"}, 32'(data_ready), 32'(e_rdy));
        chk({tag, "_overrun"}, 32'(overrun_error), 32'(e_ovr));
        chk({tag, "_framing"}, 32'(framing_error), 32'(e_fe));
    endtask

    task automatic chk_strobes(input string tag, input int n);
        chk({tag, "_stb_cnt"}, stb_q.size(), n);
        for (int k = 0; k < stb_q.size() && k < n; k++)
            chk({tag, "_stb_time"}, stb_q[k], t0 + 15 + 10 * k);
    endtask

    // Drives the first ncyc cycles of a start+8 data+stop frame, 10 clks per bit
    task automatic drive(input logic [7:0] d, input logic stop, input bit rd, input int ncyc);
        logic [9:0] b;
        b = {stop, d, 1'b0};
        stb_q.delete();
        @(posedge clk); #1;
        t0 = cyc + 1;
        for (int c = 0; c < ncyc; c++) begin
            serial_in = b[c / 10];
            data_read = rd && (c == 97);
            @(posedge clk); #1;
            if (c == 96) rdy96 = data_ready;
            if (c == 97) begin rdy97 = data_ready; rxd97 = rx_data; end
        end
        data_read = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic stop, input bit rd);
        drive(d, stop, rd, 100);
        if (stop) begin
            e_ovr  = rd ? 1'b0 : (e_rdy ? 1'b1 : e_ovr);
            e_rdy  = 1'b1;
            e_data = d;
            e_fe   = 1'b0;
        end else e_fe = 1'b1;
        chk_strobes(tag, 9);
        chk_out(tag);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic host_read(input string tag);
        data_read = 1'b1;
        @(posedge clk); #1;
        data_read = 1'b0;
        if (e_rdy) begin e_rdy = 1'b0; e_ovr = 1'b0; end
        chk_out(tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobe", 32'(shift_strobe), 32'd0);
        chk_out("reset");
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        frame("a5", 8'hA5, 1'b1, 1'b0);
        chk("a5_ready_at_96", 32'(rdy96), 32'd0);
        chk("a5_ready_at_97", 32'(rdy97), 32'd1);
        chk("a5_data_at_97", 32'(rxd97), 32'hA5);

        stb_q.delete();
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_stb_cnt", stb_q.size(), 0);
        chk_out("glitch");

        host_read("read1");
        frame("stop0", 8'h3C, 1'b0, 1'b0);

        frame("f11", 8'h11, 1'b1, 1'b0);
        frame("f22", 8'h22, 1'b1, 1'b0);
        host_read("read_ovr");

        frame("f66", 8'h66, 1'b1, 1'b0);
        frame("f77_rd_at_load", 8'h77, 1'b1, 1'b1);
        host_read("read2");

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic       stop;
            bit         rd;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            rd   = stop && ($urandom_range(0, 1) == 1);
            frame("rand", d, stop, rd);
            if ($urandom_range(0, 2) == 0) host_read("rand_read");
        end

        frame("f99", 8'h99, 1'b1, 1'b0);
        drive(8'($urandom), 1'b1, 1'b0, 55);
        chk("abort_strobe4_high", 32'(shift_strobe), 32'd1);
        chk("abort_stb_cnt", stb_q.size(), 4);
        n_rst = 1'b0;
        #1;
        e_data = 8'h00; e_rdy = 1'b0; e_ovr = 1'b0; e_fe = 1'b0;
        chk("abort_strobe", 32'(shift_strobe), 32'd0);
        chk_out("abort");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frame("f5a_after_reset", 8'h5A, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
